oam_dma_ctrl: RTL and testbench
===============================

Name: oam_dma_ctrl

Overview:
- Controls OAM DMA. A CPU write to FF46 starts a copy of XFER_LEN bytes from {page,8'h00} into OAM (FE00+).
- While a copy is running, it arbitrates the system bus between the CPU and the DMA engine. It also owns the FF46 register (write starts a copy, read returns the last value written).
- Sits beside sys_decode. It uses the ffxx decode and the cpu_wr/cpu_rd strobes, and drives the source-address mux and the OAM write port.

Parameters:
- XFER_LEN, 160, number of bytes copied per transfer (valid range 1..256).
- START_DELAY, 1, M-cycles between the FF46 write and the first source read (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- mcyc  in  1  M-cycle enable, one clk pulse per M-cycle. All state advances only when mcyc=1.
- cpu_a  in  16  CPU address.
- cpu_d_in  in  8  CPU write data.
- cpu_wr  in  1  CPU write strobe; sampled on mcyc.
- cpu_rd  in  1  CPU read strobe.
- ffxx  in  1  cpu_a[15:8]==8'hFF decode from sys_decode.
- src_rd_data  in  8  data returned from the DMA source read.
- ff46_q  out  8  FF46 register contents.
- ff46_rd_oe  out  1  drive ff46_q onto the data bus (ffxx && cpu_a[7:0]==8'h46 && cpu_rd).
- dma_active  out  1  DMA owns the external/VRAM bus and OAM.
- dma_src_a  out  16  source address, valid while src_rd=1.
- src_rd  out  1  source read request for the current M-cycle.
- oam_a  out  8  OAM write index.
- oam_wd  out  8  OAM write data.
- oam_wr  out  1  OAM write strobe, one clk wide (the mcyc clk).
- cpu_bus_grant  out  1  CPU access allowed this cycle.

Behaviour:
- Reset values: ff46_q=8'h00, state=IDLE, idx=0, all strobes 0, dma_active=0, cpu_bus_grant=1.
- FF46 write: ffxx && cpu_a[7:0]==8'h46 && cpu_wr && mcyc.
  - Loads ff46_q with cpu_d_in.
  - Loads delay counter with START_DELAY.
  - Moves to state START.
- Source page: pg = ff46_q, except pg ≥ 8'hE0 maps to pg−8'h20 (echo-RAM mirror).
  - dma_src_a = {pg, idx}.
- States (transitions on mcyc only):
  - IDLE: no activity.
  - START: count down the delay; when it reaches 0, go to XFER with idx=0.
  - XFER: src_rd=1 and a source read of idx.
    - Data is latched into a one-entry pipeline register (pipe_d, pipe_idx, pipe_v).
    - idx increments.
    - After the read of idx=XFER_LEN−1, go to LAST.
  - LAST: no read; flush the final pipeline write; go to IDLE.
- Write pipeline: a byte read in M-cycle n is written to OAM in M-cycle n+1.
  - oam_wr pulses on mcyc whenever pipe_v=1, with oam_a=pipe_idx and oam_wd=pipe_d.
  - Exactly XFER_LEN writes per completed transfer.
  - Latency: first oam_wr occurs START_DELAY+1 M-cycles after the FF46 write.
- dma_active = (state==XFER) || (state==LAST).
  - It is 0 during START, unless a previous transfer is still running (see restart).
- cpu_bus_grant = !dma_active || ffxx. The CPU may reach only FF00–FFFF (IO, HRAM, IE) during DMA.
  - Blocked CPU writes are discarded by the bus, not by this block.
  - FF46 itself is always accessible.
- Restart: an FF46 write while XFER/LAST is running:
  - The old transfer keeps running, using a separately held active page, for START_DELAY M-cycles.
  - Then idx resets to 0 with the new page.
  - dma_active stays 1 across the switch.
  - The pending pipeline write of the old transfer still completes.
- Simultaneous events: an FF46 write in the same M-cycle as the final LAST step takes priority → START, and dma_active does not glitch to 0 if a restart window applies.
- reset mid-transfer: returns to IDLE immediately and clears the pipeline. No further oam_wr.
- mcyc=0 freezes all state. Strobes are gated by mcyc.
- idx is 8 bits. XFER_LEN=256 terminates on idx==8'hFF (no wrap into a second pass).

Test Plan:
- Basic copy: write FF46=8'hC1, XFER_LEN=160.
  - First src_rd occurs 1 M-cycle later at C100.
  - 160 oam_wr pulses, oam_a 0..159 with data matching the source.
  - dma_active high for exactly 161 M-cycles; then IDLE.
- Arbitration: during DMA, CPU reads at 8000 and at FF85.
  - cpu_bus_grant=0 for 8000; =1 for FF85.
  - Reading FF46 returns 8'hC1 with ff46_rd_oe=1.
- Echo mirror: write FF46=8'hE3 → dma_src_a runs E3→C300..C39F.
- Restart: at idx=50, write FF46=8'hD0.
  - One more read occurs from the old page (C132).
  - Then reads restart at D000, idx=0.
  - dma_active never drops.
  - 160 further writes complete.
- Reset mid-transfer: assert reset at idx=80.
  - Next clk: dma_active=0, oam_wr=0, ff46_q=8'h00, cpu_bus_grant=1.
- mcyc gating: hold mcyc=0 for 10 clks mid-transfer.
  - idx, oam_a and strobes frozen.
  - Resumes without skipped or duplicated indices.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: FF46 register, OAM DMA sequencer with one-deep write pipeline, and CPU bus arbitration.
module oam_dma_ctrl #(
  parameter int XFER_LEN    = 160,
  parameter int START_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mcyc,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_d_in,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic        ffxx,
  input  logic [7:0]  src_rd_data,
  output logic [7:0]  ff46_q,
  output logic        ff46_rd_oe,
  output logic        dma_active,
  output logic [15:0] dma_src_a,
  output logic        src_rd,
  output logic [7:0]  oam_a,
  output logic [7:0]  oam_wd,
  output logic        oam_wr,
  output logic        cpu_bus_grant
);
  typedef enum logic [1:0] {IDLE, START, XFER, LAST} state_t;
  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);
  localparam logic [7:0] DLY      = 8'(START_DELAY - 1);
  localparam logic       IMM      = START_DELAY == 1;
  state_t     state_q, state_d;
  logic [7:0] ff46_d, idx_q, idx_d, pg_q, pg_d, dly_q, dly_d;
  logic [7:0] pdat_q, pdat_d, pidx_q, pidx_d;
  logic       pend_q, pend_d, win_q, win_d, pv_q, pv_d;
  logic       sel46, wr46, running, go;
  function automatic logic [7:0] mirror(input logic [7:0] p);
    return p >= 8'hE0 ? p - 8'h20 : p;
  endfunction
  assign sel46   = ffxx && cpu_a == 16'hFF46;
  assign wr46    = sel46 && cpu_wr && mcyc;
  assign running = state_q == XFER || state_q == LAST;
  // The write M-cycle itself counts as the first delay M-cycle, so a delay of 1 launches at once.
  assign go      = mcyc && (wr46 ? IMM : pend_q && dly_q == 8'd1);
  assign ff46_rd_oe    = sel46 && cpu_rd;
  // win_q keeps the bus owned while a restart is pending after the old transfer ended.
  assign dma_active    = running || (state_q == START && win_q);
  assign cpu_bus_grant = !dma_active || ffxx;
  assign dma_src_a     = {pg_q, idx_q};
  assign src_rd        = state_q == XFER && mcyc;
  assign oam_a         = pidx_q;
  assign oam_wd        = pdat_q;
  assign oam_wr        = pv_q && mcyc;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pg_d    = pg_q;
    ff46_d  = ff46_q;
    dly_d   = dly_q;
    pend_d  = pend_q;
    win_d   = win_q;
    pv_d    = pv_q;
    pdat_d  = pdat_q;
    pidx_d  = pidx_q;
    if (mcyc) begin
      pv_d    = state_q == XFER;
      pdat_d  = state_q == XFER ? src_rd_data : pdat_q;
      pidx_d  = state_q == XFER ? idx_q : pidx_q;
      idx_d   = state_q == XFER && idx_q != LAST_IDX ? idx_q + 8'd1 : idx_q;
      state_d = state_q == XFER ? (idx_q == LAST_IDX ? LAST : XFER) :
                state_q == LAST ? IDLE : state_q;
      if (wr46) begin
        ff46_d = cpu_d_in;
        pend_d = !IMM;
        dly_d  = DLY;
        win_d  = running || (pend_q && win_q);
      end else if (pend_q) begin
        dly_d  = dly_q - 8'd1;
        pend_d = dly_q != 8'd1;
      end
      if (pend_d && state_d == IDLE) state_d = START;
      if (go) begin
        state_d = XFER;
        idx_d   = 8'd0;
        pg_d    = mirror(wr46 ? cpu_d_in : ff46_q);
        win_d   = 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 8'd0;
      pg_q    <= 8'd0;
      ff46_q  <= 8'd0;
      dly_q   <= 8'd0;
      pend_q  <= 1'b0;
      win_q   <= 1'b0;
      pv_q    <= 1'b0;
      pdat_q  <= 8'd0;
      pidx_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pg_q    <= pg_d;
      ff46_q  <= ff46_d;
      dly_q   <= dly_d;
      pend_q  <= pend_d;
      win_q   <= win_d;
      pv_q    <= pv_d;
      pdat_q  <= pdat_d;
      pidx_q  <= pidx_d;
    end
  end
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: directed checks of oam_dma_ctrl copy, arbitration, echo mirror, restart, reset and mcyc gating.
module tb_oam_dma_ctrl;
  logic        clk, reset, mcyc, cpu_wr, cpu_rd, ffxx;
  logic [15:0] cpu_a, dma_src_a;
  logic [7:0]  cpu_d_in, src_rd_data, ff46_q, oam_a, oam_wd;
  logic        ff46_rd_oe, dma_active, src_rd, oam_wr, cpu_bus_grant;
  int          n_cmp = 0, n_bad = 0, mnum = 0, act = 0, rd_m = -1, wr_m = -1, w0 = 0;
  logic [15:0] ra[$];
  logic [7:0]  wa[$], wd[$];

  oam_dma_ctrl dut (
    .clk(clk), .reset(reset), .mcyc(mcyc), .cpu_a(cpu_a), .cpu_d_in(cpu_d_in),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .ffxx(ffxx), .src_rd_data(src_rd_data),
    .ff46_q(ff46_q), .ff46_rd_oe(ff46_rd_oe), .dma_active(dma_active),
    .dma_src_a(dma_src_a), .src_rd(src_rd), .oam_a(oam_a), .oam_wd(oam_wd),
    .oam_wr(oam_wr), .cpu_bus_grant(cpu_bus_grant)
  );

  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign src_rd_data = mem(dma_src_a);
  assign ffxx        = cpu_a[15:8] == 8'hFF;

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic mc();
    @(negedge clk);
    mcyc = 1;
    #1;
    if (src_rd) begin
      if (ra.size() == 0) rd_m = mnum;
      ra.push_back(dma_src_a);
    end
    if (oam_wr) begin
      if (wa.size() == 0) wr_m = mnum;
      wa.push_back(oam_a);
      wd.push_back(oam_wd);
    end
    if (dma_active) act++;
    mnum++;
    @(negedge clk);
    mcyc   = 0;
    cpu_wr = 0;
  endtask

  task automatic start(input logic [7:0] d);
    ra.delete(); wa.delete(); wd.delete();
    act = 0; rd_m = -1; wr_m = -1;
    cpu_a = 16'hFF46; cpu_d_in = d; cpu_wr = 1;
    w0 = mnum;
    mc();
    cpu_a = 16'h0000; cpu_d_in = 8'h00;
  endtask

  task automatic chk_seq(input string tag, input int off, input logic [7:0] pg, input int n);
    int e;
    logic [15:0] a;
    e = 0;
    for (int i = 0; i < n; i++) begin
      a = {pg, 8'(i)};
      if (off + i >= ra.size() || off + i >= wa.size()) e++;
      else if (ra[off+i] != a || wa[off+i] != 8'(i) || wd[off+i] != mem(a)) e++;
    end
    chk(tag, e, 0);
  endtask

  initial begin
    int e, n;
    logic [15:0] a0;
    logic [7:0]  o0;
    reset = 1; mcyc = 0; cpu_a = 0; cpu_d_in = 0; cpu_wr = 0; cpu_rd = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ff46", ff46_q, 8'h00);
    chk("rst_active", dma_active, 0);
    chk("rst_grant", cpu_bus_grant, 1);
    chk("rst_oam_wr", oam_wr, 0);
    chk("rst_src_rd", src_rd, 0);
    @(negedge clk);
    reset = 0;

    start(8'hC1);
    repeat (5) mc();
    cpu_a = 16'h8000; #1;
    chk("grant_8000", cpu_bus_grant, 0);
    cpu_a = 16'hFF85; #1;
    chk("grant_ff85", cpu_bus_grant, 1);
    cpu_a = 16'hFF46; #1;
    chk("oe_no_rd", ff46_rd_oe, 0);
    cpu_rd = 1; #1;
    chk("oe_rd", ff46_rd_oe, 1);
    chk("ff46_rdback", ff46_q, 8'hC1);
    cpu_rd = 0; cpu_a = 16'h0000;
    repeat (170) mc();
    chk("basic_rd_lat", rd_m - w0, 1);
    chk("basic_wr_lat", wr_m - w0, 2);
    chk("basic_nrd", ra.size(), 160);
    chk("basic_nwr", wa.size(), 160);
    chk_seq("basic_seq", 0, 8'hC1, 160);
    chk("basic_active", act, 161);
    chk("basic_idle", dma_active, 0);

    start(8'hE3);
    repeat (170) mc();
    chk("echo_ff46", ff46_q, 8'hE3);
    chk("echo_nrd", ra.size(), 160);
    chk_seq("echo_seq", 0, 8'hC3, 160);

    start(8'hC1);
    repeat (50) mc();
    cpu_a = 16'hFF46; cpu_d_in = 8'hD0; cpu_wr = 1;
    mc();
    cpu_a = 16'h0000;
    repeat (170) mc();
    chk("rs_nrd", ra.size(), 211);
    chk("rs_nwr", wa.size(), 211);
    chk_seq("rs_old", 0, 8'hC1, 51);
    chk_seq("rs_new", 51, 8'hD0, 160);
    chk("rs_active", act, 212);

    start(8'hC1);
    repeat (20) mc();
    a0 = dma_src_a; o0 = oam_a; e = 0;
    repeat (10) begin
      @(negedge clk); #1;
      if (src_rd || oam_wr || dma_src_a != a0 || oam_a != o0 || !dma_active) e++;
    end
    chk("frz_hold", e, 0);
    chk("frz_addr", a0, 16'hC114);
    repeat (160) mc();
    chk("frz_nwr", wa.size(), 160);
    chk_seq("frz_seq", 0, 8'hC1, 160);
    chk("frz_active", act, 161);

    start(8'hC1);
    repeat (80) mc();
    chk("mid_addr", dma_src_a, 16'hC150);
    @(negedge clk);
    reset = 1; mcyc = 1;
    @(posedge clk); #1;
    chk("mid_active", dma_active, 0);
    chk("mid_oam_wr", oam_wr, 0);
    chk("mid_ff46", ff46_q, 8'h00);
    chk("mid_grant", cpu_bus_grant, 1);
    @(negedge clk);
    reset = 0; mcyc = 0;
    n = wa.size();
    repeat (5) mc();
    chk("mid_nowr", wa.size(), n);
    chk("mid_idle", dma_active, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
